// File: rtl/quadrature_pkg.sv
// Shared direction encodings and the A/B transition decoder used by the
// quadrature decoder and its velocity estimator.
package quadrature_pkg;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef struct packed {
    logic step;
    logic dir;
    logic err;
  } ab_decode_t;

  // Gray-code walk 00->10->11->01->00 is forward; the reverse walk steps back;
  // a two-bit change in one sample cannot be attributed to either direction.
  function automatic ab_decode_t decode_ab(input logic [1:0] prev, input logic [1:0] cur);
    ab_decode_t d;
    d.step = 1'b0;
    d.dir  = DIR_FWD;
    d.err  = 1'b0;
    case ({prev, cur})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
        d.step = 1'b1;
        d.dir  = DIR_FWD;
      end
      4'b1000, 4'b1110, 4'b0111, 4'b0001: begin
        d.step = 1'b1;
        d.dir  = DIR_REV;
      end
      4'b0011, 4'b1100, 4'b0110, 4'b1001: begin
        d.err = 1'b1;
      end
      default: begin
        d.step = 1'b0;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/quadrature_velocity.sv
// Windowed step counter: accumulates signed steps over 2^P clocks and
// publishes the saturated total once per window.
module quadrature_velocity
  import quadrature_pkg::*;
#(
  parameter int V = 16,
  parameter int P = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step,
  input  logic                dir,
  output logic signed [V-1:0] velocity,
  output logic                velocity_valid
);

  localparam logic signed [V-1:0] ONE     = V'(1);
  localparam logic signed [V-1:0] ACC_MAX = {1'b0, {(V-1){1'b1}}};
  localparam logic signed [V-1:0] ACC_MIN = -ACC_MAX;

  logic [P-1:0]        win_cnt;
  logic signed [V-1:0] acc;
  logic                wrap;

  function automatic logic signed [V-1:0] step_value(input logic s, input logic d);
    if (!s) return '0;
    return (d == DIR_FWD) ? ONE : -ONE;
  endfunction

  // Symmetric clamp keeps the most negative code unused so +/- totals mirror.
  function automatic logic signed [V-1:0] sat_accumulate(input logic signed [V-1:0] a,
                                                         input logic s, input logic d);
    if (!s) return a;
    if (d == DIR_FWD) return (a >= ACC_MAX) ? ACC_MAX : a + ONE;
    return (a <= ACC_MIN) ? ACC_MIN : a - ONE;
  endfunction

  assign wrap = &win_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt        <= '0;
      acc            <= '0;
      velocity       <= '0;
      velocity_valid <= 1'b0;
    end else begin
      win_cnt        <= win_cnt + P'(1);
      velocity_valid <= wrap;
      if (wrap) begin
        velocity <= acc;
        acc      <= step_value(step, dir);
      end else begin
        acc <= sat_accumulate(acc, step, dir);
      end
    end
  end

endmodule

// File: rtl/quadrature_decoder.sv
// x4 quadrature decoder: samples A/B/Index, decodes Gray-code steps into a
// wrapping signed Position, flags illegal jumps and reports windowed velocity.
module quadrature_decoder
  import quadrature_pkg::*;
#(
  parameter int W             = 32,
  parameter int V             = 16,
  parameter int P             = 20,
  parameter bit ZERO_ON_INDEX = 1'b1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                A,
  input  logic                B,
  input  logic                Index,
  input  logic                Load,
  input  logic signed [W-1:0] Load_Value,
  input  logic                Error_Clear,
  output logic signed [W-1:0] Position,
  output logic                Direction,
  output logic                Step,
  output logic                Error,
  output logic signed [V-1:0] Velocity,
  output logic                Velocity_Valid
);

  localparam logic signed [W-1:0] POS_ONE = W'(1);

  logic [1:0]          ab_p0;
  logic [1:0]          ab_p1;
  logic                idx_p0;
  logic                idx_p1;
  logic                vld_p0;
  logic                vld_p1;
  ab_decode_t          dec;
  logic                step_p1;
  logic                err_p1;
  logic                idx_rise_p1;
  logic signed [W-1:0] delta;

  // Stage 0/1: sample register and previous-sample register. The valid bits
  // hold off decoding until both stages carry real post-reset samples.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ab_p0  <= 2'b00;
      idx_p0 <= 1'b0;
      vld_p0 <= 1'b0;
      ab_p1  <= 2'b00;
      idx_p1 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      ab_p0  <= {A, B};
      idx_p0 <= Index;
      vld_p0 <= 1'b1;
      ab_p1  <= ab_p0;
      idx_p1 <= idx_p0;
      vld_p1 <= vld_p0;
    end
  end

  // Decode: compare the newest sample against the previous one.
  always_comb begin
    dec         = decode_ab(ab_p1, ab_p0);
    step_p1     = vld_p1 && dec.step;
    err_p1      = vld_p1 && dec.err;
    idx_rise_p1 = vld_p1 && idx_p0 && !idx_p1;
    delta       = (dec.dir == DIR_FWD) ? POS_ONE : -POS_ONE;
  end

  // Stage 2: Position/Direction/Step/Error. Load outranks the index clear,
  // which outranks the step; Step and Direction still follow a masked step.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Position  <= '0;
      Direction <= 1'b0;
      Step      <= 1'b0;
      Error     <= 1'b0;
    end else begin
      Step <= step_p1;
      if (step_p1) begin
        Direction <= dec.dir;
      end
      if (Load) begin
        Position <= Load_Value;
      end else if (ZERO_ON_INDEX && idx_rise_p1) begin
        Position <= '0;
      end else if (step_p1) begin
        Position <= Position + delta;
      end
      if (err_p1) begin
        Error <= 1'b1;
      end else if (Error_Clear) begin
        Error <= 1'b0;
      end
    end
  end

  quadrature_velocity #(
    .V(V),
    .P(P)
  ) u_velocity (
    .clk           (Clk),
    .rst_n         (Reset),
    .step          (step_p1),
    .dir           (dec.dir),
    .velocity      (Velocity),
    .velocity_valid(Velocity_Valid)
  );

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder: a P=8 instance with V=16 and a twin
// with V=4 to observe velocity saturation.
module tb_quadrature_decoder;

  logic               Clk = 1'b0;
  logic               Reset = 1'b0;
  logic               A = 1'b0;
  logic               B = 1'b0;
  logic               Index = 1'b0;
  logic               Load = 1'b0;
  logic signed [31:0] Load_Value = '0;
  logic               Error_Clear = 1'b0;

  logic signed [31:0] Position;
  logic               Direction;
  logic               Step;
  logic               Error;
  logic signed [15:0] Velocity;
  logic               Velocity_Valid;

  logic signed [31:0] position_v4;
  logic               direction_v4;
  logic               step_v4;
  logic               error_v4;
  logic signed [3:0]  velocity_v4;
  logic               velocity_valid_v4;

  int total = 0;
  int bad = 0;
  int step_cnt = 0;

  quadrature_decoder #(.W(32), .V(16), .P(8), .ZERO_ON_INDEX(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .A(A), .B(B), .Index(Index), .Load(Load),
    .Load_Value(Load_Value), .Error_Clear(Error_Clear), .Position(Position),
    .Direction(Direction), .Step(Step), .Error(Error), .Velocity(Velocity),
    .Velocity_Valid(Velocity_Valid)
  );

  quadrature_decoder #(.W(32), .V(4), .P(8), .ZERO_ON_INDEX(1'b1)) dut_v4 (
    .Clk(Clk), .Reset(Reset), .A(A), .B(B), .Index(Index), .Load(Load),
    .Load_Value(Load_Value), .Error_Clear(Error_Clear), .Position(position_v4),
    .Direction(direction_v4), .Step(step_v4), .Error(error_v4), .Velocity(velocity_v4),
    .Velocity_Valid(velocity_valid_v4)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) if (Step === 1'b1) step_cnt <= step_cnt + 1;

  task automatic set_ab(input logic [1:0] ab);
    {A, B} = ab;
  endtask

  task automatic test_reset();
    Reset = 1'b0; A = 1'b1; B = 1'b1; Index = 1'b0; Load = 1'b0; Error_Clear = 1'b0;
    repeat (3) @(negedge Clk);
    total++; if (Position !== 32'sd0) begin bad++; $display("FAIL rst_pos got=%0d want=0", Position); end
    total++; if (Step !== 1'b0) begin bad++; $display("FAIL rst_step got=%b want=0", Step); end
    total++; if (Error !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", Error); end
    total++; if (Direction !== 1'b0) begin bad++; $display("FAIL rst_dir got=%b want=0", Direction); end
    total++; if (Velocity !== 16'sd0) begin bad++; $display("FAIL rst_vel got=%0d want=0", Velocity); end
    total++; if (Velocity_Valid !== 1'b0) begin bad++; $display("FAIL rst_vv got=%b want=0", Velocity_Valid); end
    Reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      total++;
      if (Step !== 1'b0 || Error !== 1'b0 || Position !== 32'sd0) begin
        bad++;
        $display("FAIL prime_quiet cyc=%0d got step=%b err=%b pos=%0d want 0/0/0", i, Step, Error, Position);
      end
    end
  endtask

  task automatic test_forward();
    logic [1:0] seq [8];
    int c0;
    seq = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
    c0 = step_cnt;
    for (int i = 0; i < 8; i++) begin
      set_ab(seq[i]);
      @(negedge Clk);
      total++;
      if (Position !== 32'(i) || Step !== 1'b0) begin
        bad++;
        $display("FAIL fwd_early[%0d] got pos=%0d step=%b want pos=%0d step=0", i, Position, Step, i);
      end
      @(negedge Clk);
      total++;
      if (Position !== 32'(i + 1) || Step !== 1'b1 || Direction !== 1'b1) begin
        bad++;
        $display("FAIL fwd_step[%0d] got pos=%0d step=%b dir=%b want pos=%0d step=1 dir=1",
                 i, Position, Step, Direction, i + 1);
      end
    end
    repeat (3) @(negedge Clk);
    total++; if (Position !== 32'sd8) begin bad++; $display("FAIL fwd_pos got=%0d want=8", Position); end
    total++; if (step_cnt - c0 !== 8) begin bad++; $display("FAIL fwd_pulses got=%0d want=8", step_cnt - c0); end
  endtask

  task automatic test_reverse_wrap();
    int c0;
    Load_Value = 32'sd0; Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    total++; if (Position !== 32'sd0) begin bad++; $display("FAIL load0 got=%0d want=0", Position); end
    c0 = step_cnt;
    set_ab(2'b10); repeat (2) @(negedge Clk);
    set_ab(2'b00); repeat (2) @(negedge Clk);
    set_ab(2'b01); repeat (3) @(negedge Clk);
    total++; if (Position !== 32'hFFFF_FFFD) begin bad++; $display("FAIL rev_wrap got=%h want=fffffffd", Position); end
    total++; if (Direction !== 1'b0) begin bad++; $display("FAIL rev_dir got=%b want=0", Direction); end
    total++; if (step_cnt - c0 !== 3) begin bad++; $display("FAIL rev_pulses got=%0d want=3", step_cnt - c0); end
  endtask

  task automatic test_error();
    int c0;
    set_ab(2'b00); repeat (3) @(negedge Clk);
    total++; if (Position !== 32'hFFFF_FFFE) begin bad++; $display("FAIL err_pre_pos got=%h want=fffffffe", Position); end
    c0 = step_cnt;
    set_ab(2'b11); repeat (3) @(negedge Clk);
    total++; if (Error !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", Error); end
    total++; if (Position !== 32'hFFFF_FFFE) begin bad++; $display("FAIL err_pos_hold got=%h want=fffffffe", Position); end
    total++; if (Direction !== 1'b1) begin bad++; $display("FAIL err_dir_hold got=%b want=1", Direction); end
    total++; if (step_cnt !== c0) begin bad++; $display("FAIL err_no_step got=%0d want=%0d", step_cnt, c0); end
    Error_Clear = 1'b1;
    @(negedge Clk);
    Error_Clear = 1'b0;
    total++; if (Error !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", Error); end
    set_ab(2'b01); repeat (2) @(negedge Clk);
    set_ab(2'b00); repeat (3) @(negedge Clk);
    total++;
    if (Position !== 32'sd0 || Error !== 1'b0) begin
      bad++; $display("FAIL err_legal got pos=%0d err=%b want pos=0 err=0", Position, Error);
    end
    set_ab(2'b11);
    @(negedge Clk);
    Error_Clear = 1'b1;
    @(negedge Clk);
    Error_Clear = 1'b0;
    total++; if (Error !== 1'b1) begin bad++; $display("FAIL err_clear_collide got=%b want=1", Error); end
    @(negedge Clk);
    total++; if (Error !== 1'b1 || Position !== 32'sd0) begin
      bad++; $display("FAIL err_sticky got err=%b pos=%0d want err=1 pos=0", Error, Position);
    end
    Error_Clear = 1'b1;
    @(negedge Clk);
    Error_Clear = 1'b0;
  endtask

  task automatic test_load_index();
    set_ab(2'b01); Index = 1'b1;
    @(negedge Clk);
    Load = 1'b1; Load_Value = 32'sd100;
    @(negedge Clk);
    Load = 1'b0;
    total++; if (Position !== 32'sd100) begin bad++; $display("FAIL load_prio got=%0d want=100", Position); end
    total++; if (Step !== 1'b1 || Direction !== 1'b1) begin
      bad++; $display("FAIL load_step got step=%b dir=%b want 1/1", Step, Direction);
    end
    Index = 1'b0;
    repeat (3) @(negedge Clk);
    total++; if (Position !== 32'sd100) begin bad++; $display("FAIL idx_fall got=%0d want=100", Position); end
    Index = 1'b1;
    @(negedge Clk);
    total++; if (Position !== 32'sd100) begin bad++; $display("FAIL idx_early got=%0d want=100", Position); end
    @(negedge Clk);
    total++; if (Position !== 32'sd0) begin bad++; $display("FAIL idx_zero got=%0d want=0", Position); end
    Index = 1'b0;
    Load = 1'b1; Load_Value = 32'sd50;
    @(negedge Clk);
    Load = 1'b0;
    repeat (2) @(negedge Clk);
    set_ab(2'b11); Index = 1'b1;
    repeat (2) @(negedge Clk);
    total++; if (Position !== 32'sd0 || Step !== 1'b1 || Direction !== 1'b0) begin
      bad++; $display("FAIL idx_step got pos=%0d step=%b dir=%b want 0/1/0", Position, Step, Direction);
    end
    Index = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_velocity();
    logic [1:0]         fwd [4];
    logic [1:0]         rev [4];
    int                 vv_cnt;
    int                 vv_at [3];
    logic signed [15:0] vel_seen [3];
    logic signed [3:0]  v4_seen [3];
    fwd = '{2'b10, 2'b11, 2'b01, 2'b00};
    rev = '{2'b01, 2'b11, 2'b10, 2'b00};
    vv_cnt = 0;
    for (int i = 0; i < 3; i++) begin vv_at[i] = 0; vel_seen[i] = '0; v4_seen[i] = '0; end
    Reset = 1'b0; set_ab(2'b00); Index = 1'b0;
    repeat (2) @(negedge Clk);
    total++; if (Velocity !== 16'sd0 || Velocity_Valid !== 1'b0) begin
      bad++; $display("FAIL vel_rst got vel=%0d vv=%b want 0/0", Velocity, Velocity_Valid);
    end
    Reset = 1'b1;
    for (int n = 1; n <= 780; n++) begin
      @(negedge Clk);
      if (Velocity_Valid === 1'b1) begin
        if (vv_cnt < 3) begin
          vv_at[vv_cnt] = n; vel_seen[vv_cnt] = Velocity; v4_seen[vv_cnt] = velocity_v4;
        end
        vv_cnt++;
      end
      if (n >= 3 && n < 43) set_ab(fwd[(n - 3) % 4]);
      else if (n >= 270 && n < 290) set_ab(fwd[(n - 270) % 4]);
      else if (n >= 530 && n < 550) set_ab(rev[(n - 530) % 4]);
    end
    total++; if (vv_cnt !== 3) begin bad++; $display("FAIL vv_count got=%0d want=3", vv_cnt); end
    total++; if (vv_at[0] !== 256) begin bad++; $display("FAIL vv_first got=%0d want=256", vv_at[0]); end
    total++; if (vv_at[1] !== 512) begin bad++; $display("FAIL vv_second got=%0d want=512", vv_at[1]); end
    total++; if (vv_at[2] !== 768) begin bad++; $display("FAIL vv_third got=%0d want=768", vv_at[2]); end
    total++; if (vel_seen[0] !== 16'sd40) begin bad++; $display("FAIL vel_w1 got=%0d want=40", vel_seen[0]); end
    total++; if (vel_seen[1] !== 16'sd20) begin bad++; $display("FAIL vel_w2 got=%0d want=20", vel_seen[1]); end
    total++; if (vel_seen[2] !== -16'sd20) begin bad++; $display("FAIL vel_w3 got=%0d want=-20", vel_seen[2]); end
    total++; if (v4_seen[0] !== 4'sd7) begin bad++; $display("FAIL v4_w1 got=%0d want=7", v4_seen[0]); end
    total++; if (v4_seen[1] !== 4'sd7) begin bad++; $display("FAIL v4_w2 got=%0d want=7", v4_seen[1]); end
    total++; if (v4_seen[2] !== -4'sd7) begin bad++; $display("FAIL v4_w3 got=%0d want=-7", v4_seen[2]); end
    total++; if (Position !== 32'sd40) begin bad++; $display("FAIL vel_pos got=%0d want=40", Position); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse_wrap();
    test_error();
    test_load_index();
    test_velocity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quadrature_decoder.md
QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning the Position width in bits (two's complement).
REQ-002 The block SHALL have parameter V, default 16, meaning the Velocity width in bits (two's complement).
REQ-003 The block SHALL have parameter P, default 20, meaning the velocity window of 2^P clocks (about 21 ms at 50 MHz).
REQ-004 The block SHALL have parameter ZERO_ON_INDEX, default 1, meaning a rising Index edge clears Position when set to 1.
REQ-005 The block SHALL have port Clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port A, input, 1 bit: encoder channel A, already debounced and synchronous to Clk.
REQ-008 The block SHALL have port B, input, 1 bit: encoder channel B, already debounced and synchronous to Clk.
REQ-009 The block SHALL have port Index, input, 1 bit: encoder index, already debounced and synchronous to Clk.
REQ-010 The block SHALL have port Load, input, 1 bit: a one-cycle strobe that writes Load_Value into Position.
REQ-011 The block SHALL have port Load_Value, input, W bits: the Position preset value.
REQ-012 The block SHALL have port Error_Clear, input, 1 bit: a one-cycle strobe that clears Error.
REQ-013 The block SHALL have port Position, output, W bits: the signed x4 count.
REQ-014 The block SHALL have port Direction, output, 1 bit: the direction of the last valid step (1 = forward).
REQ-015 The block SHALL have port Step, output, 1 bit: a one-cycle pulse per valid step.
REQ-016 The block SHALL have port Error, output, 1 bit: sticky illegal-transition flag.
REQ-017 The block SHALL have port Velocity, output, V bits: the signed step count of the last completed window.
REQ-018 The block SHALL have port Velocity_Valid, output, 1 bit: a one-cycle pulse when Velocity updates.

Function
REQ-019 The block SHALL register {A,B,Index} once into a sample stage and keep one previous-sample stage; decoding compares the two stages.
REQ-020 Forward transitions ({A,B} prev->new) SHALL be 00->10, 10->11, 11->01 and 01->00, each adding +1.
REQ-021 Reverse transitions SHALL be the inverse of the forward set, each adding -1.
REQ-022 An unchanged {A,B} SHALL produce no step.
REQ-023 A change of both A and B in one sample SHALL set Error and SHALL NOT change Position, Direction or Step.
REQ-024 Position, Direction and Step SHALL update on the second rising Clk edge after an A/B change is presented at the inputs.
REQ-025 Position SHALL wrap modulo 2^W with no saturation.
REQ-026 An Index rising edge (previous 0, sample 1) with ZERO_ON_INDEX=1 SHALL set Position to 0.
REQ-027 When an Index rising edge and a valid step occur in the same cycle, Position SHALL become 0 and Step and Direction SHALL still reflect the step.
REQ-028 Load SHALL set Position to Load_Value on the next edge, with priority over both Index and step.
REQ-029 Error_Clear SHALL clear Error unless an illegal transition occurs in the same cycle, in which case Error stays 1.
REQ-030 A free-running P-bit window counter SHALL drive a signed step accumulator that counts +1/-1 per valid step.
REQ-031 On window counter wrap, Velocity SHALL take the accumulator value, Velocity_Valid SHALL pulse, and the accumulator SHALL restart at that cycle's step value (0 or +/-1).
REQ-032 The accumulator SHALL saturate at +/-(2^(V-1)-1).
REQ-033 The window SHALL NOT be affected by Load or Index.
REQ-034 The first sample after reset release SHALL prime the previous-sample stage without producing a step or Error, whatever the A/B levels are.

Reset
REQ-035 While Reset=0, all outputs SHALL be 0, with Position=0 and Velocity=0.
REQ-036 While Reset=0, the window counter, the accumulator, the sample stages and the primed flag SHALL be cleared.
REQ-037 Reset assertion mid-window SHALL discard the partial window.
REQ-038 After Reset release, the first Velocity_Valid SHALL occur 2^P clocks after release.

Structure
REQ-039 Package quadrature_pkg SHALL hold the direction encoding constants and a function that maps {prev,new} A/B to step/error.
REQ-040 The window counter, accumulator and saturation SHALL be a sub-module named quadrature_velocity.
REQ-041 The top level SHALL hold the sampling, decode, Position, Index and Load logic.

Verification
REQ-042 Bench: reset with A=1, B=1, then release -> no Step, Error=0, Position=0.
REQ-043 Bench: 8 forward steps (00,10,11,01,00,...) -> Position=8, Direction=1, 8 Step pulses, each Position update two edges after the input change.
REQ-044 Bench: Position=0, then 3 reverse steps -> Position=2^W-3 (wrap), Direction=0.
REQ-045 Bench: AB 00->11 -> Error=1, Position unchanged; Error_Clear -> Error=0; Error_Clear together with another 00->11 -> Error stays 1.
REQ-046 Bench: Load with Load_Value=100 in the same cycle as an Index rise and a forward step -> Position=100; Index rise alone -> Position=0.
REQ-047 Bench: P=8, 40 forward steps inside one 256-clock window -> Velocity=40 with a single Velocity_Valid; V=4 with 20 steps -> Velocity=7.
